// File: rtl/mandelbrot_pixel_sink.sv
// Result-stream sink: maps iteration counts to colors and writes them to the framebuffer.
// Optional palette RAM replaces the fixed color map when MANDELBROT_PALETTE_EN is defined.
module mandelbrot_pixel_sink #(
    parameter int unsigned IW = 8,
    parameter int unsigned AW = 12,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          start,
    input  logic [AW:0]   npixels,
    output logic          done,
    output logic [AW:0]   pix_left,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [IW-1:0] in_dat,
    input  logic [AW-1:0] in_adr,
    output logic          mem_wr,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_adr,
    output logic [PW-1:0] mem_dat
`ifdef MANDELBROT_PALETTE_EN
    ,
    input  logic          pal_we,
    input  logic [IW-1:0] pal_adr,
    input  logic [PW-1:0] pal_dat
`endif
);

    localparam int unsigned RGB_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          start_q;
    logic          start_edge;
    logic          a_vld;
    logic [IW-1:0] a_dat;
    logic [AW-1:0] a_adr;
    logic          b_adv;
    logic          accept;
    logic          commit;
    logic [PW-1:0] color;

    assign start_edge = start && !start_q;
    assign b_adv      = !mem_wr || mem_ack;
    assign in_rdy     = (state_q == S_RUN) && clk_en && (!a_vld || b_adv);
    assign accept     = in_vld && in_rdy;
    assign commit     = clk_en && mem_wr && mem_ack;

`ifdef MANDELBROT_PALETTE_EN
    localparam int unsigned DEPTH = 1 << IW;

    logic [PW-1:0] pal_mem [DEPTH];

    // Palette RAM; contents are not reset
    always_ff @(posedge clk) begin
        if (clk_en && pal_we) begin
            pal_mem[pal_adr] <= pal_dat;
        end
    end

    // Read-before-write: stage B captures the old entry on a same-cycle write
    assign color = pal_mem[a_dat];
`else
    logic [RGB_W-1:0] rgb;

    // Fixed map: saturated iteration count renders black
    always_comb begin
        rgb = {a_dat[IW-1:IW-5], a_dat[IW-1:IW-6], ~a_dat[IW-1:IW-5]};
        if (a_dat == '1) begin
            rgb = '0;
        end
        color = PW'(rgb);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (clk_en && start_edge) begin
                    state_d = (npixels == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (commit && pix_left == (AW+1)'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame control: start edge detect, pixel countdown, done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            done     <= 1'b0;
            pix_left <= '0;
        end else if (clk_en) begin
            start_q <= start;
            done    <= (state_d == S_DONE);
            if (state_q != S_RUN && start_edge) begin
                pix_left <= npixels;
            end else if (state_q == S_RUN && commit && pix_left != '0) begin
                pix_left <= pix_left - (AW+1)'(1);
            end
        end
    end

    // Two-stage pipeline; stage B is the framebuffer write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld   <= 1'b0;
            a_dat   <= '0;
            a_adr   <= '0;
            mem_wr  <= 1'b0;
            mem_adr <= '0;
            mem_dat <= '0;
        end else if (clk_en) begin
            if (b_adv) begin
                mem_wr <= a_vld;
                if (a_vld) begin
                    mem_adr <= a_adr;
                    mem_dat <= color;
                end
            end
            if (accept) begin
                a_vld <= 1'b1;
                a_dat <= in_dat;
                a_adr <= in_adr;
            end else if (b_adv) begin
                a_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Scoreboard bench for mandelbrot_pixel_sink: directed frames with hand-computed colors.
module tb_mandelbrot_pixel_sink;

    localparam int unsigned IW = 8;
    localparam int unsigned AW = 12;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          start;
    logic [AW:0]   npixels;
    logic          done;
    logic [AW:0]   pix_left;
    logic          in_vld;
    logic          in_rdy;
    logic [IW-1:0] in_dat;
    logic [AW-1:0] in_adr;
    logic          mem_wr;
    logic          mem_ack;
    logic [AW-1:0] mem_adr;
    logic [PW-1:0] mem_dat;
`ifdef MANDELBROT_PALETTE_EN
    logic          pal_we;
    logic [IW-1:0] pal_adr;
    logic [PW-1:0] pal_dat;
    logic [PW-1:0] pal_model [256];
`endif

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [PW-1:0] dat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mandelbrot_pixel_sink #(.IW(IW), .AW(AW), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .start    (start),
        .npixels  (npixels),
        .done     (done),
        .pix_left (pix_left),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_dat   (in_dat),
        .in_adr   (in_adr),
        .mem_wr   (mem_wr),
        .mem_ack  (mem_ack),
        .mem_adr  (mem_adr),
        .mem_dat  (mem_dat)
`ifdef MANDELBROT_PALETTE_EN
        ,
        .pal_we   (pal_we),
        .pal_adr  (pal_adr),
        .pal_dat  (pal_dat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_color(input logic [IW-1:0] it);
`ifdef MANDELBROT_PALETTE_EN
        return pal_model[it];
`else
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        if (it == 8'hFF) return 16'h0000;
        r = it[7:3];
        g = it[7:2];
        b = ~it[7:3];
        return {r, g, b};
`endif
    endfunction

    // Monitor: samples just before the active edge, pops on every committed write
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && clk_en && mem_wr && mem_ack) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write",
                             mem_adr, mem_dat);
                end else begin
                    mon_e = q.pop_front();
                    check("wr_adr", 32'(mem_adr), 32'(mon_e.adr));
                    check("wr_dat", 32'(mem_dat), 32'(mon_e.dat));
                end
            end
        end
    end

    task automatic send_exp(input logic [AW-1:0] adr, input logic [IW-1:0] it,
                            input logic [PW-1:0] dat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_vld = 1'b1;
        in_adr = adr;
        in_dat = it;
        #1;
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_rdy 0 for adr 0x%0h, expected 1", adr);
            in_vld = 1'b0;
        end else begin
            e.adr = adr;
            e.dat = dat;
            q.push_back(e);
            @(posedge clk);
            #1 in_vld = 1'b0;
        end
    endtask

    task automatic send(input logic [AW-1:0] adr, input logic [IW-1:0] it);
        send_exp(adr, it, exp_color(it));
    endtask

    task automatic pulse_start(input logic [AW:0] n);
        @(negedge clk);
        npixels = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        npixels = '0;
        in_vld  = 1'b0;
        in_dat  = '0;
        in_adr  = '0;
        mem_ack = 1'b0;
`ifdef MANDELBROT_PALETTE_EN
        pal_we  = 1'b0;
        pal_adr = '0;
        pal_dat = '0;
`endif
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pix_left", 32'(pix_left), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MANDELBROT_PALETTE_EN
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            @(negedge clk);
            pal_we  = 1'b1;
            pal_adr = v;
            pal_dat = {v, ~v};
            pal_model[v] = {v, ~v};
        end
        @(negedge clk);
        pal_we = 1'b0;
`endif

        // Zero-pixel frame
        mem_ack = 1'b1;
        pulse_start('0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_pix_left", 32'(pix_left), 32'd0);
        repeat (3) @(negedge clk);
        check("zero_no_wr", 32'(mem_wr), 32'd0);

        // Basic four-pixel frame
        pulse_start(13'd4);
        check("basic_done_clr", 32'(done), 32'd0);
        check("basic_pix_left", 32'(pix_left), 32'd4);
`ifdef MANDELBROT_PALETTE_EN
        send(12'd0, 8'd0);
        send(12'd1, 8'd16);
        send(12'd2, 8'd255);
        send(12'd3, 8'd128);
`else
        send_exp(12'd0, 8'd0,   16'h001F);
        send_exp(12'd1, 8'd16,  16'h109D);
        send_exp(12'd2, 8'd255, 16'h0000);
        send_exp(12'd3, 8'd128, 16'h840F);
`endif
        wait_done("basic_done");
        check("basic_pix_left_end", 32'(pix_left), 32'd0);
        check("basic_q_empty", 32'(q.size()), 32'd0);

        // Backpressure: ack held low for five cycles mid-frame
        pulse_start(13'd6);
        fork
            begin
                for (int i = 0; i < 6; i++) send(12'(16 + i), 8'(i * 20));
            end
            begin
                repeat (3) @(negedge clk);
                mem_ack = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                check("bp_in_rdy", 32'(in_rdy), 32'd0);
                check("bp_mem_wr", 32'(mem_wr), 32'd1);
                @(negedge clk);
                mem_ack = 1'b1;
            end
        join
        wait_done("bp_done");
        check("bp_q_empty", 32'(q.size()), 32'd0);

        // Restart during RUN must be ignored
        pulse_start(13'd3);
        send(12'h100, 8'd7);
        pulse_start(13'd8);
        send(12'h101, 8'd63);
        send(12'h102, 8'd254);
        wait_done("restart_done");
        check("restart_pix_left", 32'(pix_left), 32'd0);
        check("restart_q_empty", 32'(q.size()), 32'd0);

        // Clock-enable gating
        pulse_start(13'd2);
        @(negedge clk);
        clk_en = 1'b0;
        in_vld = 1'b1;
        in_dat = 8'd9;
        in_adr = 12'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ce_in_rdy", 32'(in_rdy), 32'd0);
            check("ce_pix_left", 32'(pix_left), 32'd2);
            @(negedge clk);
        end
        clk_en = 1'b1;
        in_vld = 1'b0;
        send(12'h200, 8'd9);
        send(12'h201, 8'd200);
        wait_done("ce_done");

`ifdef MANDELBROT_PALETTE_EN
        @(negedge clk);
        pal_we  = 1'b1;
        pal_adr = 8'd5;
        pal_dat = 16'hABCD;
        pal_model[5] = 16'hABCD;
        @(negedge clk);
        pal_we = 1'b0;
        pulse_start(13'd1);
        send_exp(12'h300, 8'd5, 16'hABCD);
        wait_done("pal_done");
`endif

        // Async reset with a write pending
        pulse_start(13'd2);
        mem_ack = 1'b0;
        send(12'h3FF, 8'd200);
        n = 0;
        while (!mem_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ar_pending_wr", 32'(mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mem_wr", 32'(mem_wr), 32'd0);
        check("ar_in_rdy", 32'(in_rdy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_pix_left", 32'(pix_left), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("ar_idle_rdy", 32'(in_rdy), 32'd0);
        check("ar_idle_done", 32'(done), 32'd0);

        // Recovery frame after reset
        pulse_start(13'd1);
        send(12'h010, 8'd100);
        wait_done("post_rst_done");
        check("post_rst_q_empty", 32'(q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
